gost_round_ctrl: RTL
====================

// Module: gost_round_ctrl
// PURPOSE
//  Iterative GOST 28147-89 block engine (ECB, one round per clock) built around the
//  existing 8x4-bit S-box array. It latches one 64-bit block and a 256-bit key, then
//  sequences 32 Feistel rounds with the standard key schedule for encrypt or decrypt.
//  It returns the result on a valid/ready handshake. This is the top datapath
//  controller for the cipher core.
// PARAMETERS
//  ROUNDS   32  Feistel round count; fixed by the standard, exposed only for test
//  ROT_AMT  11  left-rotate amount applied to the S-box output
// PORTS
//  CLK         in   1    single clock; all state updates on posedge
//  RST         in   1    synchronous, active-high reset
//  DIN_VALID   in   1    input block/key/mode valid
//  DIN_READY   out  1    engine can accept a block (high only in IDLE)
//  DIN         in   64   [31:0]=N1 (A), [63:32]=N2 (B)
//  KEY         in   256  K0=KEY[31:0] ... K7=KEY[255:224]
//  DECRYPT     in   1    0=encrypt schedule, 1=decrypt schedule
//  DOUT_VALID  out  1    result valid; held until DOUT_READY
//  DOUT_READY  in   1    downstream accepts result
//  DOUT        out  64   result block
//  BUSY        out  1    high in RUN or DONE
//  ROUND       out  5    current round index (debug/verification)
// BEHAVIOUR
//  Clock/reset: one clock. Reset is synchronous and active-high.
//  Reset: state=IDLE. DIN_READY=1. DOUT_VALID=0. DOUT=0. BUSY=0. ROUND=0.
//    The internal A, B, key and mode registers are cleared.
//  FSM:
//    IDLE --(DIN_VALID&DIN_READY)--> RUN
//    RUN  --(ROUND==ROUNDS-1)-->     DONE
//    DONE --(DOUT_READY)-->          IDLE
//  Accept (IDLE, DIN_VALID=1): latch A=DIN[31:0], B=DIN[63:32], KEY and DECRYPT.
//    Set ROUND=0.
//  RUN, each cycle:
//    t = rol(S(A + K[idx]) mod 2^32, ROT_AMT) ^ B
//    B <= A; A <= t; ROUND <= ROUND+1 (5-bit, wraps to 0 on the DONE transition)
//  Key index, with r = ROUND:
//    Encrypt: idx = r[2:0] for r<24, else 7-r[2:0].
//    Decrypt: idx = r[2:0] for r<8,  else 7-r[2:0].
//  Final round: registers update as normal. On entry to DONE, DOUT <= {A_new, B_new}.
//    This undoes the last swap: DOUT[63:32]=N2_out and DOUT[31:0]=N1_out.
//  Latency: block accepted at cycle T gives DOUT_VALID=1 at T+33.
//    Minimum issue interval is 34 cycles (DONE->IDLE costs one cycle).
//  DIN_READY is 0 in RUN and DONE. DIN_VALID there is ignored and its data is not latched.
//  DONE: DOUT and DOUT_VALID stay stable until DOUT_READY=1.
//    On the handshake cycle DOUT_VALID falls next cycle. DOUT holds its last value.
//  Latched KEY/DECRYPT changes during RUN have no effect; they are sampled only at accept.
//  RST mid-RUN or in DONE: the block is abandoned, the next cycle is IDLE with reset
//    values, and no DOUT_VALID is produced for the aborted block.
//  Arithmetic: 32-bit add with carry discarded. S-box array is purely combinational
//    in the round path.
// STRUCTURE
//  Shared include gost_defs.vh holds: GOST_ROUNDS=32, GOST_ROT=11, the state
//    encodings IDLE/RUN/DONE, and the key-index function.
//  Sub-module gost_round (combinational): A, B, K -> t. It instantiates the existing
//    S-box array. The FSM, counter and registers stay in gost_round_ctrl.
// TESTING
//  1 Encrypt, KEY=0, DIN=0 -> DOUT equals the C/Python golden model using the same
//    sbox0..7 tables. DOUT_VALID rises exactly 33 cycles after accept.
//  2 Round trip: encrypt DIN=64'h0123456789ABCDEF with a random KEY, feed DOUT back
//    with DECRYPT=1 -> DIN is recovered bit-exact.
//  3 Backpressure: hold DOUT_READY=0 for 10 cycles in DONE -> DOUT/DOUT_VALID stable,
//    DIN_READY=0. Release -> IDLE next cycle.
//  4 Drive DIN_VALID with a different DIN during RUN -> not latched; result matches
//    the first block only.
//  5 Assert RST at ROUND=17 -> next cycle IDLE, all outputs at reset values, no
//    DOUT_VALID. A fresh block afterwards gives the correct result.
//  6 Key schedule: monitor ROUND/idx for encrypt and decrypt over all 32 rounds ->
//    enc = 0..7 x3 then 7..0; dec = 0..7 then 7..0 x3.

Source files
------------

// File: rtl/gost_round_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the GOST round engine.
// Holds the 8x4-bit S-box array (tc26 "Z" parameter set) and key schedule.
package gost_round_ctrl_pkg;

  localparam int GOST_ROUNDS = 32;
  localparam int GOST_ROT    = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row i is S-box i; entry j sits in nibble j (LSB nibble = input 0).
  localparam logic [63:0] SBOX [8] = '{
    64'h1F307D8E9B5A264C,
    64'hF0DB74E1C5A93286,
    64'h069C471EDAF2853B,
    64'hB9E35A076F4D128C,
    64'hC24BE390D618A5F7,
    64'h0E34187BAC296FD5,
    64'h73AD0B4FC19652E8,
    64'h2BC96AF43850DE71
  };

  function automatic logic [31:0] sbox_sub(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[4*i +: 4] = SBOX[i][{x[4*i +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  // Late rounds run the key words backwards: 7 - r[2:0] == ~r[2:0].
  function automatic logic [2:0] key_idx(
    input logic [4:0] r,
    input logic       dec
  );
    logic fwd;
    fwd = dec ? (r < 5'd8) : (r < 5'd24);
    return fwd ? r[2:0] : ~r[2:0];
  endfunction

endpackage

// File: rtl/gost_round_ctrl_round.sv
// One combinational GOST Feistel round: t = rol(S(A + K), ROT) ^ B.
// Carry out of the 32-bit add is discarded.
module gost_round_ctrl_round
  import gost_round_ctrl_pkg::*;
#(
  parameter int ROT_AMT = GOST_ROT
) (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] k_i,
  output logic [31:0] t_o
);

  logic [31:0] sum;
  logic [31:0] sub;
  logic [31:0] rot;

  assign sum = a_i + k_i;
  assign sub = sbox_sub(sum);
  assign rot = (sub << ROT_AMT) | (sub >> (32 - ROT_AMT));
  assign t_o = rot ^ b_i;

endmodule

// File: rtl/gost_round_ctrl.sv
// Iterative GOST 28147-89 ECB engine: one Feistel round per clock,
// valid/ready in and out, inputs sampled only at accept.
module gost_round_ctrl
  import gost_round_ctrl_pkg::*;
#(
  parameter int ROUNDS  = GOST_ROUNDS,
  parameter int ROT_AMT = GOST_ROT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  input  logic [63:0]  DIN,
  input  logic [255:0] KEY,
  input  logic         DECRYPT,
  output logic         DOUT_VALID,
  input  logic         DOUT_READY,
  output logic [63:0]  DOUT,
  output logic         BUSY,
  output logic [4:0]   ROUND
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_e         state_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [255:0]   key_q;
  logic           dec_q;
  logic [4:0]     round_q;
  logic [63:0]    dout_q;
  logic           dout_vld_q;

  logic [2:0]     idx;
  logic [31:0]    k_sel;
  logic [31:0]    a_d;

  assign idx   = key_idx(round_q, dec_q);
  assign k_sel = key_q[{idx, 5'd0} +: 32];

  gost_round_ctrl_round #(
    .ROT_AMT (ROT_AMT)
  ) u_round (
    .a_i (a_q),
    .b_i (b_q),
    .k_i (k_sel),
    .t_o (a_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      key_q      <= '0;
      dec_q      <= 1'b0;
      round_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (DIN_VALID) begin
            a_q     <= DIN[31:0];
            b_q     <= DIN[63:32];
            key_q   <= KEY;
            dec_q   <= DECRYPT;
            round_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= a_q;
          round_q <= round_q + 5'd1;
          // Output order {A_new, B_new} cancels the final swap.
          if (round_q == LAST) begin
            round_q    <= '0;
            dout_q     <= {a_d, a_q};
            dout_vld_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (DOUT_READY) begin
            dout_vld_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DIN_READY  = (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign DOUT_VALID = dout_vld_q;
  assign DOUT       = dout_q;
  assign ROUND      = round_q;

endmodule
